// File: rtl/msg_pkg.sv
// rtl/msg_pkg.sv - shared state encoding and default sizing for the message arbiter
package msg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } msg_state_e;

    localparam int N_DEF       = 4;
    localparam int DW_DEF      = 8;
    localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin pick: first set request at or after ptr+1, wrapping
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] winner
);

    // Walk the rotated order from lowest to highest priority so the
    // highest-priority set bit is the last one written.
    always_comb begin
        valid  = |req;
        winner = '0;
        for (int k = N; k >= 1; k--) begin
            if (req[IW'((int'(ptr) + k) % N)]) begin
                winner = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/msg_arbiter.sv
// rtl/msg_arbiter.sv - round-robin owner of the message serializer; optional watchdog via MSG_ARB_TIMEOUT_EN
module msg_arbiter
    import msg_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] msg_in,
    input  logic            done,
    output logic [N-1:0]    grant,
    output logic [N-1:0]    ack,
    output logic            start,
    output logic [DW-1:0]   sel_data,
    output logic            busy,
    output logic            err
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    msg_state_e    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] ptr_q, ptr_d;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;

`ifdef MSG_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CW-1:0] wdog_q, wdog_d;
    logic          to_q, to_d;
`endif

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    // State, owner index and rotation pointer; reset leaves index 0 on top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= IW'(N - 1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef MSG_ARB_TIMEOUT_EN
    // Watchdog count of WAIT cycles and the abort flag shown during RELEASE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= '0;
            to_q   <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            to_q   <= to_d;
        end
    end
`endif

    // Next state: req only matters in IDLE, done only in WAIT.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
`ifdef MSG_ARB_TIMEOUT_EN
        wdog_d  = wdog_q;
        to_d    = to_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = LAUNCH;
                    idx_d   = pick_idx;
                end
            end
            LAUNCH: begin
                state_d = WAIT;
`ifdef MSG_ARB_TIMEOUT_EN
                wdog_d  = '0;
                to_d    = 1'b0;
`endif
            end
            WAIT: begin
                if (done) begin
                    state_d = RELEASE;
`ifdef MSG_ARB_TIMEOUT_EN
                end else if (wdog_q == CW'(TIMEOUT - 1)) begin
                    state_d = RELEASE;
                    to_d    = 1'b1;
                end else begin
                    wdog_d  = wdog_q + 1'b1;
`endif
                end
            end
            RELEASE: begin
                state_d = IDLE;
                ptr_d   = idx_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from state and owner index.
    always_comb begin
        grant    = '0;
        ack      = '0;
        start    = 1'b0;
        sel_data = '0;
        busy     = (state_q != IDLE);
        err      = 1'b0;
        if (state_q != IDLE) begin
            grant    = N'(1) << idx_q;
            sel_data = msg_in[int'(idx_q) * DW +: DW];
        end
        if (state_q == LAUNCH) begin
            start = 1'b1;
        end
        if (state_q == RELEASE) begin
            ack = N'(1) << idx_q;
`ifdef MSG_ARB_TIMEOUT_EN
            err = to_q;
`endif
        end
    end

endmodule

// File: tb/tb_msg_arbiter.sv
// tb/tb_msg_arbiter.sv - self-checking bench for msg_arbiter; watchdog checks follow MSG_ARB_TIMEOUT_EN
module tb_msg_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
`ifdef MSG_ARB_TIMEOUT_EN
    localparam int TO = 10;
`else
    localparam int TO = 255;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] msg_in;
    logic            done;
    logic [N-1:0]    grant;
    logic [N-1:0]    ack;
    logic            start;
    logic [DW-1:0]   sel_data;
    logic            busy;
    logic            err;

    always #5 clk = ~clk;

    msg_arbiter #(.N(N), .DW(DW), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .msg_in   (msg_in),
        .done     (done),
        .grant    (grant),
        .ack      (ack),
        .start    (start),
        .sel_data (sel_data),
        .busy     (busy),
        .err      (err)
    );

    int errors = 0;
    int checks = 0;
    int m_ptr;

    typedef struct {
        bit              do_rst;
        logic [N-1:0]    req;
        logic [N*DW-1:0] msg;
        int              dly;
        bit              hold;
        bit              glitch;
        int              exp_idx;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    function automatic logic [DW-1:0] slice(input logic [N*DW-1:0] m, input int i);
        return m[i*DW +: DW];
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"},  32'(busy),     32'd0);
        chk({tag, ".grant"}, 32'(grant),    32'd0);
        chk({tag, ".start"}, 32'(start),    32'd0);
        chk({tag, ".ack"},   32'(ack),      32'd0);
        chk({tag, ".err"},   32'(err),      32'd0);
        chk({tag, ".sel"},   32'(sel_data), 32'd0);
    endtask

    task automatic chk_active(input string tag, input int idx, input bit st, input bit ak,
                              input bit e, input logic [DW-1:0] sel);
        chk({tag, ".busy"},  32'(busy),     32'd1);
        chk({tag, ".grant"}, 32'(grant),    32'(oh(idx)));
        chk({tag, ".start"}, 32'(start),    32'(st));
        chk({tag, ".ack"},   32'(ak ? oh(idx) : '0), 32'(ack) ^ 32'(ak ? oh(idx) : '0) ^ 32'(ak ? oh(idx) : '0));
        chk({tag, ".err"},   32'(err),      32'(e));
        chk({tag, ".sel"},   32'(sel_data), 32'(sel));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk_idle("rst_async");
        @(negedge clk);
        rst   = 1'b0;
        m_ptr = N - 1;
        chk_idle("rst_release");
    endtask

    task automatic txn(input logic [N-1:0] r, input logic [N*DW-1:0] m, input int dly,
                       input bit hold, input bit glitch, input int exp_idx);
        logic [DW-1:0] es;
        es = slice(m, exp_idx);
        if (glitch) begin
            req  = '0;
            done = 1'b1;
            @(negedge clk);
            chk_idle("done_in_idle");
            done = 1'b0;
        end
        req    = r;
        msg_in = m;
        @(negedge clk);
        chk_active("launch", exp_idx, 1'b1, 1'b0, 1'b0, es);
        if (!hold) req = '0;
        if (glitch) done = 1'b1;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            done = 1'b0;
            chk_active("wait", exp_idx, 1'b0, 1'b0, 1'b0, es);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk_active("release", exp_idx, 1'b0, 1'b1, 1'b0, es);
        @(negedge clk);
        chk_idle("idle_after");
        m_ptr = exp_idx;
    endtask

    initial begin
        rst    = 1'b1;
        req    = '0;
        done   = 1'b0;
        msg_in = '0;
        m_ptr  = N - 1;

        tbl[0]  = '{1'b1, 4'b0100, 32'h44A5_2211, 5, 1'b0, 1'b0, 2};
        tbl[1]  = '{1'b1, 4'b1111, 32'h8C7B_6A59, 3, 1'b1, 1'b0, 0};
        tbl[2]  = '{1'b0, 4'b1111, 32'h8C7B_6A59, 3, 1'b1, 1'b0, 1};
        tbl[3]  = '{1'b0, 4'b1111, 32'h8C7B_6A59, 3, 1'b1, 1'b0, 2};
        tbl[4]  = '{1'b0, 4'b1111, 32'h8C7B_6A59, 3, 1'b1, 1'b0, 3};
        tbl[5]  = '{1'b0, 4'b1111, 32'h8C7B_6A59, 3, 1'b1, 1'b0, 0};
        tbl[6]  = '{1'b0, 4'b1001, 32'hF0E1_D2C3, 2, 1'b1, 1'b0, 3};
        tbl[7]  = '{1'b0, 4'b0001, 32'h1234_5678, 2, 1'b0, 1'b1, 0};
        tbl[8]  = '{1'b0, 4'b0010, 32'hDEAD_BEEF, 1, 1'b0, 1'b0, 1};
        tbl[9]  = '{1'b1, 4'b1000, 32'h0F1E_2D3C, 1, 1'b0, 1'b0, 3};
        tbl[10] = '{1'b0, 4'b0110, 32'h5566_7788, 2, 1'b1, 1'b0, 1};
        tbl[11] = '{1'b0, 4'b0110, 32'h5566_7788, 2, 1'b1, 1'b0, 2};
        tbl[12] = '{1'b0, 4'b0110, 32'h5566_7788, 2, 1'b0, 1'b0, 1};

        @(negedge clk);
        do_reset();

        foreach (tbl[i]) begin
            if (tbl[i].do_rst) do_reset();
            txn(tbl[i].req, tbl[i].msg, tbl[i].dly, tbl[i].hold, tbl[i].glitch, tbl[i].exp_idx);
        end

        req    = 4'b0100;
        msg_in = 32'h00C3_0000;
        @(negedge clk);
        chk_active("rstmid.launch", model_pick(4'b0100, m_ptr), 1'b1, 1'b0, 1'b0, 8'hC3);
        @(negedge clk);
        @(negedge clk);
        chk_active("rstmid.wait", model_pick(4'b0100, m_ptr), 1'b0, 1'b0, 1'b0, 8'hC3);
        req = '0;
        do_reset();
        @(negedge clk);
        chk_idle("rstmid.no_ack");
        txn(4'b0001, 32'h0000_0096, 2, 1'b0, 1'b0, 0);

        begin
            int w;
            w = model_pick(4'b0010, m_ptr);
            req    = 4'b0010;
            msg_in = 32'h0000_3C00;
            @(negedge clk);
            chk_active("wd.launch", w, 1'b1, 1'b0, 1'b0, 8'h3C);
            req = '0;
`ifdef MSG_ARB_TIMEOUT_EN
            for (int i = 0; i < TO; i++) begin
                @(negedge clk);
                chk_active("wd.wait", w, 1'b0, 1'b0, 1'b0, 8'h3C);
            end
            @(negedge clk);
            chk_active("wd.release", w, 1'b0, 1'b1, 1'b1, 8'h3C);
            @(negedge clk);
            chk_idle("wd.idle");
            m_ptr = w;
            txn(4'b0100, 32'h0077_0000, TO, 1'b0, 1'b0, model_pick(4'b0100, m_ptr));
`else
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                chk_active("wd.hang", w, 1'b0, 1'b0, 1'b0, 8'h3C);
            end
            do_reset();
`endif
        end

        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] r;
            r = N'($urandom_range(0, (1 << N) - 1));
            if (r == '0) begin
                req = '0;
                @(negedge clk);
                chk_idle("rnd.idle");
            end else begin
                txn(r, {$urandom, $urandom} >> 0, $urandom_range(1, 4),
                    1'($urandom_range(0, 1)), 1'b0, model_pick(r, m_ptr));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/msg_arbiter.md
# msg_arbiter

- Shares the single message serializer datapath and its message controller among N requesters.
- Picks one requester by round-robin and drives that requester's message word onto the datapath.
- Issues a one-cycle start to the message controller, waits for its done, then acknowledges the winner.
- Sits between requesting blocks and the message controller/shift-register datapath.

## Interface
Parameters:
- N, 4: number of requesters (2..8)
- DW, 8: message word width
- TIMEOUT, 255: watchdog limit in cycles (used only with MSG_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  N  per-requester request level
- msg_in  in  N*DW  requester messages; slice i = msg_in[i*DW +: DW]
- done  in  1  completion pulse from message controller
- grant  out  N  one-hot owner of datapath
- ack  out  N  one-hot one-cycle completion pulse to owner
- start  out  1  one-cycle start to message controller
- sel_data  out  DW  selected message word to datapath load port
- busy  out  1  high whenever state is not IDLE
- err  out  1  one-cycle pulse, watchdog abort

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RELEASE.
- IDLE -> LAUNCH when |req.
  - Winner = first set req bit at or after (ptr+1) mod N.
  - Winner index latched into idx.
- LAUNCH -> WAIT unconditionally.
- WAIT -> RELEASE on done.
- RELEASE -> IDLE unconditionally; ptr <= idx.
- Outputs are Moore, decoded from state and idx:
  - grant = onehot(idx) in LAUNCH/WAIT/RELEASE, else 0.
  - start = 1 only in LAUNCH.
  - ack = onehot(idx) only in RELEASE.
  - sel_data = msg_in slice idx in all non-IDLE states, 0 in IDLE.
- req is sampled only in IDLE.
  - Dropping req mid-transaction does not abort; the transaction completes and ack is still pulsed.
- done is sampled only in WAIT. done in LAUNCH or IDLE is ignored.
- A requester holding req after its ack is rotated to lowest priority. With all N requesting, grants cycle 0,1,…,N-1,0.
- ptr wrap: ptr = N-1 makes index 0 the highest priority.

## Timing
- Reset values: state IDLE, idx 0, ptr N-1, grant 0, ack 0, start 0, busy 0, err 0, sel_data 0.
- Rst asserted in any state returns to IDLE immediately. No ack or err is generated for the aborted transaction.
- Latency:
  - req high at edge k (state IDLE) -> grant and start at cycle k+1.
  - done in cycle m (WAIT) -> ack in cycle m+1 -> IDLE at m+2.
- Minimum transaction is 4 cycles (IDLE, LAUNCH, WAIT with done, RELEASE).
- Back-to-back: the next grant comes 2 cycles after ack, since IDLE occupies one cycle.
- sel_data is stable from LAUNCH through RELEASE. The controller's load in the cycle after start sees a stable word.

## Configuration
- MSG_ARB_TIMEOUT_EN defined:
  - An 8-bit+ watchdog counter clears in LAUNCH and increments each WAIT cycle.
  - When the counter reaches TIMEOUT without done, the FSM goes WAIT -> RELEASE with err=1 for the RELEASE cycle.
  - ack still pulses in that cycle, so the owner always gets closure.
  - done in the same cycle as the limit: done wins, err=0.
- Not defined: no counter; err tied 0; WAIT waits indefinitely.

## Structure
- Shared package msg_pkg:
  - state encoding constants (IDLE=2'd0, LAUNCH=2'd1, WAIT=2'd2, RELEASE=2'd3);
  - default N/DW/TIMEOUT constants.
- Sub-module rr_pick (combinational): inputs req[N], ptr; outputs valid and winner index.
  - Implemented as a rotated priority encoder.
  - Reusable by other arbiters.

## Test plan
- Reset then req=4'b0100, msg slice2=8'hA5:
  - grant=4'b0100 and start=1 one cycle later; sel_data=8'hA5;
  - done after 5 cycles -> ack=4'b0100 next cycle; busy falls after.
- req=4'b1111 held, done 3 cycles after each start: grants in order 0001,0010,0100,1000,0001.
- req=4'b1001 after requester 0 served: grant 3 before 0. Then with ptr=3 and req=4'b0001, grant wraps to 0.
- done pulsed during LAUNCH and during IDLE -> ignored; transaction completes only on the later done in WAIT.
- rst pulsed mid-WAIT -> all outputs 0 next cycle, no ack; a new req=4'b0001 is granted to index 0 as in the first scenario.
- With MSG_ARB_TIMEOUT_EN and TIMEOUT=10, no done -> RELEASE with err=1 and ack pulsed, then IDLE. Without the macro, same stimulus -> busy stays high and err stays 0.
